pipelined_cpu: RTL and testbench

// - 5-stage (IF/ID/EX/MEM/WB) in-order pipelined 32-bit MIPS-subset CPU; top level of the processor.
// - Holds its own instruction memory, data memory and register file. Benches preload these by hierarchy.
// - Has load-use stall detection, EX forwarding and branch/jump resolution in ID with a one-slot flush.

---
 rtl/pipelined_cpu.sv | 370 +++++++++++++++++++++++++++++++++++++
 tb/tb_pipelined_cpu.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cpu.sv
// 5-stage in-order MIPS-subset CPU (IF/ID/EX/MEM/WB) with its own memories.
// Load-use stalls, EX-stage forwarding, and branch/jump resolution in ID
// with a one-slot IF/ID flush.

package pipelined_cpu_pkg;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_MUL} alu_op_e;
endpackage

// Program counter register
module pc_reg (
  input  logic        gclk,
  input  logic        grst_n,
  input  logic        en,
  input  logic [31:0] pc_i,
  output logic [31:0] pc_o
);
  // PC advances only when enabled (not stalled, run enabled)
  always_ff @(posedge gclk or negedge grst_n)
    if (!grst_n) pc_o <= '0;
    else if (en) pc_o <= pc_i;
endmodule

// Instruction ROM; contents are preloaded, load port is normally tied off
module instr_mem #(
  parameter int WORDS = 256,
  parameter int AW    = 8
) (
  input  logic          gclk,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic [AW-1:0] addr,
  output logic [31:0]   instr
);
  logic [31:0] memory [0:WORDS-1];

  // Optional word load (unused in normal operation)
  always_ff @(posedge gclk)
    if (load_en) memory[load_addr] <= load_data;

  assign instr = memory[addr];
endmodule

// 32x32 register file, r0 hardwired to zero, WB write visible to same-cycle read
module reg_file (
  input  logic        gclk,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] register [0:31];

  // Write port; r0 is never written
  always_ff @(posedge gclk)
    if (we && wa != 5'd0) register[wa] <= wd;

  assign rd1 = (ra1 == 5'd0) ? '0 : (we && wa == ra1) ? wd : register[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : (we && wa == ra2) ? wd : register[ra2];
endmodule

// Byte-wide data memory, 4-byte little-endian access, address wraps
module data_mem #(
  parameter int BYTES = 32,
  parameter int AW    = 5
) (
  input  logic          gclk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [7:0]    memory [0:BYTES-1];
  logic [AW-1:0] a1, a2, a3;

  assign a1 = addr + AW'(1);
  assign a2 = addr + AW'(2);
  assign a3 = addr + AW'(3);

  // Store word, LSB at the lowest byte address
  always_ff @(posedge gclk)
    if (we) begin
      memory[addr] <= wdata[7:0];
      memory[a1]   <= wdata[15:8];
      memory[a2]   <= wdata[23:16];
      memory[a3]   <= wdata[31:24];
    end

  assign rdata = {memory[a3], memory[a2], memory[a1], memory[addr]};
endmodule

// Main decoder; unknown opcodes/functs decode to all-zero controls (NOP)
module control
  import pipelined_cpu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       Jump_o,
  output logic       Branch_o,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       alu_src,
  output logic       reg_dst,
  output alu_op_e    alu_ctrl
);
  // Opcode / funct decode
  always_comb begin
    Jump_o     = 1'b0;
    Branch_o   = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    alu_ctrl   = ALU_ADD;
    case (opcode)
      6'h00: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        case (funct)
          6'h20:   alu_ctrl = ALU_ADD;
          6'h22:   alu_ctrl = ALU_SUB;
          6'h24:   alu_ctrl = ALU_AND;
          6'h25:   alu_ctrl = ALU_OR;
          6'h18:   alu_ctrl = ALU_MUL;
          default: reg_write = 1'b0;
        endcase
      end
      6'h08: begin reg_write = 1'b1; alu_src = 1'b1; end
      6'h23: begin reg_write = 1'b1; alu_src = 1'b1; mem_read = 1'b1; mem_to_reg = 1'b1; end
      6'h2B: begin mem_write = 1'b1; alu_src = 1'b1; end
      6'h04: Branch_o = 1'b1;
      6'h02: Jump_o   = 1'b1;
      default: ;
    endcase
  end
endmodule

// Load-use hazard detector
module hazard_unit (
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       mux8_o
);
  assign mux8_o = ex_mem_read && (ex_rt == id_rs || ex_rt == id_rt);
endmodule

// Flush request combiner
module or_gate (
  input  logic a,
  input  logic b,
  output logic or_o
);
  assign or_o = a | b;
endmodule

// Top level
module pipelined_cpu
  import pipelined_cpu_pkg::*;
#(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_BYTES = 32
) (
  input logic clk_i,
  input logic rst_i,
  input logic start_i
);
  localparam int IA = $clog2(IMEM_WORDS);
  localparam int DA = $clog2(DMEM_BYTES);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } if_id_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    alu_op_e     alu_ctrl;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
  } id_ex_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        mem_to_reg;
    logic [4:0]  dst;
    logic [31:0] alu_y;
    logic [31:0] store_data;
  } ex_mem_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [4:0]  dst;
    logic [31:0] alu_y;
    logic [31:0] load_data;
  } mem_wb_t;

  if_id_t  if_id;
  id_ex_t  id_ex, id_ex_d;
  ex_mem_t ex_mem, ex_mem_d;
  mem_wb_t mem_wb, mem_wb_d;

  logic [31:0] pc, pc_plus4, pc_next, fetch_instr;
  logic [31:0] id_instr, id_imm, rd1, rd2, br_target, j_target;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] wb_data, fwd_a, fwd_b, alu_b, alu_y, load_data;
  logic        stall, hold, flush, br_taken;
  logic        c_reg_write, c_mem_read, c_mem_write, c_mem_to_reg, c_alu_src, c_reg_dst;
  alu_op_e     c_alu_ctrl;

  // ---------------- IF ----------------
  assign pc_plus4 = pc + 32'd4;

  pc_reg PC (
    .gclk(clk_i), .grst_n(rst_i), .en(!hold), .pc_i(pc_next), .pc_o(pc)
  );

  instr_mem #(.WORDS(IMEM_WORDS), .AW(IA)) Instruction_Memory (
    .gclk(clk_i), .load_en(1'b0), .load_addr('0), .load_data('0),
    .addr(pc[IA+1:2]), .instr(fetch_instr)
  );

  // ---------------- ID ----------------
  assign id_instr = if_id.instr;
  assign id_rs    = id_instr[25:21];
  assign id_rt    = id_instr[20:16];
  assign id_rd    = id_instr[15:11];
  assign id_imm   = {{16{id_instr[15]}}, id_instr[15:0]};

  reg_file Registers (
    .gclk(clk_i), .we(mem_wb.reg_write), .wa(mem_wb.dst), .wd(wb_data),
    .ra1(id_rs), .ra2(id_rt), .rd1(rd1), .rd2(rd2)
  );

  control Control (
    .opcode(id_instr[31:26]), .funct(id_instr[5:0]),
    .Jump_o(), .Branch_o(), .reg_write(c_reg_write), .mem_read(c_mem_read),
    .mem_write(c_mem_write), .mem_to_reg(c_mem_to_reg), .alu_src(c_alu_src),
    .reg_dst(c_reg_dst), .alu_ctrl(c_alu_ctrl)
  );

  hazard_unit HD (
    .ex_mem_read(id_ex.mem_read), .ex_rt(id_ex.rt),
    .id_rs(id_rs), .id_rt(id_rt), .mux8_o(stall)
  );

  // A stopped core is treated like a stall: IF/ID holds its instruction so a
  // pending branch is re-evaluated on restart instead of being lost.
  assign hold     = stall | ~start_i;
  assign br_taken = Control.Branch_o && (rd1 == rd2);

  or_gate OR_Flush (
    .a(Control.Jump_o & ~hold), .b(br_taken & ~hold), .or_o(flush)
  );

  assign br_target = if_id.pc4 + {id_imm[29:0], 2'b00};
  assign j_target  = {if_id.pc4[31:28], id_instr[25:0], 2'b00};
  assign pc_next   = !flush ? pc_plus4 : (Control.Jump_o ? j_target : br_target);

  // Decoded ID/EX payload
  always_comb begin
    id_ex_d            = '0;
    id_ex_d.reg_write  = c_reg_write;
    id_ex_d.mem_read   = c_mem_read;
    id_ex_d.mem_write  = c_mem_write;
    id_ex_d.mem_to_reg = c_mem_to_reg;
    id_ex_d.alu_src    = c_alu_src;
    id_ex_d.alu_ctrl   = c_alu_ctrl;
    id_ex_d.rs         = id_rs;
    id_ex_d.rt         = id_rt;
    id_ex_d.dst        = c_reg_dst ? id_rd : id_rt;
    id_ex_d.a          = rd1;
    id_ex_d.b          = rd2;
    id_ex_d.imm        = id_imm;
  end

  // ---------------- EX ----------------
  // Operand forwarding, EX/MEM has priority over MEM/WB
  always_comb begin
    fwd_a = id_ex.a;
    if (ex_mem.reg_write && ex_mem.dst != 5'd0 && ex_mem.dst == id_ex.rs)
      fwd_a = ex_mem.alu_y;
    else if (mem_wb.reg_write && mem_wb.dst != 5'd0 && mem_wb.dst == id_ex.rs)
      fwd_a = wb_data;
    fwd_b = id_ex.b;
    if (ex_mem.reg_write && ex_mem.dst != 5'd0 && ex_mem.dst == id_ex.rt)
      fwd_b = ex_mem.alu_y;
    else if (mem_wb.reg_write && mem_wb.dst != 5'd0 && mem_wb.dst == id_ex.rt)
      fwd_b = wb_data;
  end

  assign alu_b = id_ex.alu_src ? id_ex.imm : fwd_b;

  // ALU, 32-bit wrap-around
  always_comb begin
    case (id_ex.alu_ctrl)
      ALU_SUB: alu_y = fwd_a - alu_b;
      ALU_AND: alu_y = fwd_a & alu_b;
      ALU_OR:  alu_y = fwd_a | alu_b;
      ALU_MUL: alu_y = fwd_a * alu_b;
      default: alu_y = fwd_a + alu_b;
    endcase
  end

  // EX/MEM payload
  always_comb begin
    ex_mem_d            = '0;
    ex_mem_d.reg_write  = id_ex.reg_write;
    ex_mem_d.mem_write  = id_ex.mem_write;
    ex_mem_d.mem_to_reg = id_ex.mem_to_reg;
    ex_mem_d.dst        = id_ex.dst;
    ex_mem_d.alu_y      = alu_y;
    ex_mem_d.store_data = fwd_b;
  end

  // ---------------- MEM ----------------
  data_mem #(.BYTES(DMEM_BYTES), .AW(DA)) Data_Memory (
    .gclk(clk_i), .we(ex_mem.mem_write), .addr(ex_mem.alu_y[DA-1:0]),
    .wdata(ex_mem.store_data), .rdata(load_data)
  );

  // MEM/WB payload
  always_comb begin
    mem_wb_d            = '0;
    mem_wb_d.reg_write  = ex_mem.reg_write;
    mem_wb_d.mem_to_reg = ex_mem.mem_to_reg;
    mem_wb_d.dst        = ex_mem.dst;
    mem_wb_d.alu_y      = ex_mem.alu_y;
    mem_wb_d.load_data  = load_data;
  end

  // ---------------- WB ----------------
  assign wb_data = mem_wb.mem_to_reg ? mem_wb.load_data : mem_wb.alu_y;

  // Pipeline registers; reset leaves every stage as a NOP
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      if_id  <= '0;
      id_ex  <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
    end else begin
      if (!hold) if_id <= flush ? '0 : if_id_t'{instr: fetch_instr, pc4: pc_plus4};
      id_ex  <= hold ? '0 : id_ex_d;
      ex_mem <= ex_mem_d;
      mem_wb <= mem_wb_d;
    end

  // Bits intentionally not consumed (shamt, PC bits outside IMEM, high address bits)
  logic unused_bits;
  assign unused_bits = ^{id_instr[10:6], pc[31:IA+2], pc[1:0], ex_mem.alu_y[31:DA]};
endmodule

// File: tb/tb_pipelined_cpu.sv
// Directed bench for pipelined_cpu: programs are preloaded by hierarchy,
// results checked against hand-computed values.
module tb_pipelined_cpu;
  logic clk, rst_n, start;
  int tests = 0, fails = 0, stalls = 0, flushes = 0;

  pipelined_cpu dut (.clk_i(clk), .rst_i(rst_n), .start_i(start));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {6'h00, rs, rt, rd, 5'h00, funct};
  endfunction

  function automatic logic [31:0] jtype(input logic [25:0] tgt);
    return {6'h02, tgt};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n cycles, sampling hazard/flush strobes mid-cycle
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (dut.HD.mux8_o === 1'b1) stalls++;
      if (dut.OR_Flush.or_o === 1'b1) flushes++;
    end
  endtask

  // Hold reset and clear all storage
  task automatic prep();
    rst_n = 1'b0;
    start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] = 32'h0;
    for (int i = 0; i < 32; i++)  dut.Data_Memory.memory[i] = 8'h0;
    for (int i = 0; i < 32; i++)  dut.Registers.register[i] = 32'h0;
  endtask

  task automatic go();
    rst_n   = 1'b1;
    start   = 1'b1;
    stalls  = 0;
    flushes = 0;
  endtask

  task automatic put(input int idx, input logic [31:0] w);
    dut.Instruction_Memory.memory[idx] = w;
  endtask

  function automatic logic [31:0] dword(input int a);
    return {dut.Data_Memory.memory[a+3], dut.Data_Memory.memory[a+2],
            dut.Data_Memory.memory[a+1], dut.Data_Memory.memory[a]};
  endfunction

  initial begin
    rst_n = 1'b0;
    start = 1'b0;

    // Reset and start control
    prep();
    check("rst_pc", dut.PC.pc_o, 32'd0);
    check("rst_stall", {31'b0, dut.HD.mux8_o}, 32'd0);
    check("rst_flush", {31'b0, dut.OR_Flush.or_o}, 32'd0);
    rst_n = 1'b1;
    tick(1);
    check("hold_pc0", dut.PC.pc_o, 32'd0);
    tick(1);
    check("hold_pc1", dut.PC.pc_o, 32'd0);
    start = 1'b1;
    tick(1);
    check("run_pc4", dut.PC.pc_o, 32'd4);
    tick(1);
    check("run_pc8", dut.PC.pc_o, 32'd8);
    tick(1);
    check("run_pc12", dut.PC.pc_o, 32'd12);

    // Forwarding chain and write-back latency
    prep();
    put(0, itype(6'h08, 5'd0, 5'd8, 16'd5));
    put(1, itype(6'h08, 5'd8, 5'd9, 16'd3));
    put(2, rtype(5'd9, 5'd8, 5'd10, 6'h20));
    go();
    tick(4);
    check("lat_r8_early", dut.Registers.register[8], 32'd0);
    tick(1);
    check("lat_r8", dut.Registers.register[8], 32'd5);
    tick(10);
    check("fwd_r9", dut.Registers.register[9], 32'd8);
    check("fwd_r10", dut.Registers.register[10], 32'd13);
    check("fwd_stalls", stalls, 32'd0);
    check("fwd_flushes", flushes, 32'd0);

    // Load-use stall
    prep();
    dut.Data_Memory.memory[0] = 8'd5;
    put(0, itype(6'h23, 5'd0, 5'd8, 16'd0));
    put(1, rtype(5'd8, 5'd8, 5'd9, 6'h20));
    go();
    tick(15);
    check("lu_r8", dut.Registers.register[8], 32'd5);
    check("lu_r9", dut.Registers.register[9], 32'd10);
    check("lu_stalls", stalls, 32'd1);
    check("lu_flushes", flushes, 32'd0);

    // Branch taken
    prep();
    put(0, itype(6'h04, 5'd0, 5'd0, 16'd1));
    put(1, itype(6'h08, 5'd0, 5'd8, 16'd1));
    put(2, itype(6'h08, 5'd0, 5'd9, 16'd2));
    go();
    tick(12);
    check("bt_r8", dut.Registers.register[8], 32'd0);
    check("bt_r9", dut.Registers.register[9], 32'd2);
    check("bt_flushes", flushes, 32'd1);

    // Branch not taken
    prep();
    dut.Registers.register[1] = 32'd1;
    put(0, itype(6'h04, 5'd1, 5'd0, 16'd1));
    put(1, itype(6'h08, 5'd0, 5'd8, 16'd1));
    put(2, itype(6'h08, 5'd0, 5'd9, 16'd2));
    go();
    tick(12);
    check("bn_r8", dut.Registers.register[8], 32'd1);
    check("bn_r9", dut.Registers.register[9], 32'd2);
    check("bn_flushes", flushes, 32'd0);

    // Jump to word 3
    prep();
    put(0, jtype(26'd3));
    put(1, itype(6'h08, 5'd0, 5'd8, 16'd1));
    put(2, itype(6'h08, 5'd0, 5'd9, 16'd2));
    put(3, itype(6'h08, 5'd0, 5'd10, 16'd3));
    go();
    tick(12);
    check("j_r8", dut.Registers.register[8], 32'd0);
    check("j_r9", dut.Registers.register[9], 32'd0);
    check("j_r10", dut.Registers.register[10], 32'd3);
    check("j_flushes", flushes, 32'd1);

    // Stall takes precedence over a dependent branch, which then redirects
    prep();
    put(0, itype(6'h23, 5'd0, 5'd8, 16'd0));
    put(1, itype(6'h04, 5'd8, 5'd8, 16'd1));
    put(2, itype(6'h08, 5'd0, 5'd9, 16'd1));
    put(3, itype(6'h08, 5'd0, 5'd10, 16'd2));
    go();
    tick(14);
    check("pr_r9", dut.Registers.register[9], 32'd0);
    check("pr_r10", dut.Registers.register[10], 32'd2);
    check("pr_stalls", stalls, 32'd1);
    check("pr_flushes", flushes, 32'd1);

    // ALU operations, unknown opcode, negative immediate
    prep();
    dut.Registers.register[1] = 32'd7;
    dut.Registers.register[2] = 32'hFFFF_FFFD;
    put(0, rtype(5'd1, 5'd2, 5'd3, 6'h20));
    put(1, rtype(5'd1, 5'd2, 5'd4, 6'h22));
    put(2, rtype(5'd1, 5'd2, 5'd5, 6'h24));
    put(3, rtype(5'd1, 5'd2, 5'd6, 6'h25));
    put(4, rtype(5'd1, 5'd2, 5'd7, 6'h18));
    put(5, itype(6'h3F, 5'd0, 5'd8, 16'h1234));
    put(6, itype(6'h08, 5'd0, 5'd11, 16'hFFFF));
    go();
    tick(16);
    check("alu_add", dut.Registers.register[3], 32'd4);
    check("alu_sub", dut.Registers.register[4], 32'd10);
    check("alu_and", dut.Registers.register[5], 32'd5);
    check("alu_or", dut.Registers.register[6], 32'hFFFF_FFFF);
    check("alu_mul", dut.Registers.register[7], 32'hFFFF_FFEB);
    check("unk_nop", dut.Registers.register[8], 32'd0);
    check("addi_neg", dut.Registers.register[11], 32'hFFFF_FFFF);

    // Stores: little-endian layout and address wrap
    prep();
    dut.Registers.register[9]  = 32'h0102_0304;
    dut.Registers.register[10] = 32'hAABB_CCDD;
    put(0, itype(6'h2B, 5'd0, 5'd9, 16'd28));
    put(1, itype(6'h2B, 5'd0, 5'd10, 16'd32));
    go();
    tick(10);
    check("sw_b28", {24'b0, dut.Data_Memory.memory[28]}, 32'h04);
    check("sw_b31", {24'b0, dut.Data_Memory.memory[31]}, 32'h01);
    check("sw_word28", dword(28), 32'h0102_0304);
    check("sw_wrap0", dword(0), 32'hAABB_CCDD);
    check("sw_b4", {24'b0, dut.Data_Memory.memory[4]}, 32'h00);

    // Fibonacci, n=5: a ends at F(5)=5, b at F(6)=8
    prep();
    put(0,  itype(6'h08, 5'd0, 5'd1, 16'd0));
    put(1,  itype(6'h08, 5'd0, 5'd2, 16'd1));
    put(2,  itype(6'h08, 5'd0, 5'd3, 16'd5));
    put(3,  itype(6'h08, 5'd0, 5'd5, 16'd0));
    put(4,  rtype(5'd1, 5'd2, 5'd4, 6'h20));
    put(5,  itype(6'h08, 5'd2, 5'd1, 16'd0));
    put(6,  itype(6'h08, 5'd4, 5'd2, 16'd0));
    put(7,  itype(6'h08, 5'd5, 5'd5, 16'd1));
    put(8,  itype(6'h08, 5'd0, 5'd0, 16'd0));
    put(9,  itype(6'h08, 5'd0, 5'd0, 16'd0));
    put(10, itype(6'h04, 5'd5, 5'd3, 16'd1));
    put(11, jtype(26'd4));
    put(12, itype(6'h2B, 5'd0, 5'd1, 16'd0));
    put(13, itype(6'h2B, 5'd0, 5'd2, 16'd4));
    go();
    tick(200);
    check("fib_mem0", dword(0), 32'd5);
    check("fib_mem4", dword(4), 32'd8);
    check("fib_i", dut.Registers.register[5], 32'd5);
    check("fib_flushes", flushes, 32'd5);
    check("fib_stalls", stalls, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
